hsid_mse_min_sel: RTL

Downstream stage of `hsid_mse_reg`: consumes the stream of per-reference MSE results (`mse_value`, `mse_ref`, `mse_valid`) produced for one pixel against the spectral library. It tracks the running minimum and maximum MSE and their reference indices. After a programmed number of results it raises `done` with the best-match (argmin) library index. One instance serves one pixel at a time; a `start` pulse begins each pixel.

---
 rtl/hsid_mse_min_sel.sv | 117 +++++++++++
 1 files changed

// File: rtl/hsid_mse_min_sel.sv
// Purpose: track the min/max MSE and their library indices over one pixel's stream of results; done carries the argmin.
// Latency: a result accepted at edge N shows in min/max at N+1; the last result gives a one-cycle done in cycle N+1.
// Backpressure: none; results are accepted every cycle in RUN, and results outside RUN are dropped and flag error.
module hsid_mse_min_sel #(
    parameter  int WORD_WIDTH            = 32,
    parameter  int HSI_LIBRARY_SIZE      = 256,
    localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [HSI_LIBRARY_SIZE_ADDR:0]   library_size,
    input  logic [WORD_WIDTH-1:0]            mse_value,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_ref,
    input  logic                             mse_valid,
    output logic [WORD_WIDTH-1:0]            min_mse_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_mse_ref,
    output logic [WORD_WIDTH-1:0]            max_mse_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] max_mse_ref,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [HSI_LIBRARY_SIZE_ADDR:0] LIB_MAX = (HSI_LIBRARY_SIZE_ADDR+1)'(HSI_LIBRARY_SIZE);
    localparam logic [HSI_LIBRARY_SIZE_ADDR:0] CNT_ONE = (HSI_LIBRARY_SIZE_ADDR+1)'(1);

    state_t                         state;
    logic [HSI_LIBRARY_SIZE_ADDR:0] size_q;
    // One bit wider than an index so a full library count does not wrap.
    logic [HSI_LIBRARY_SIZE_ADDR:0] count;
    logic [HSI_LIBRARY_SIZE_ADDR:0] count_nxt;
    logic                           size_ok;
    logic                           first_res;

    assign count_nxt = count + CNT_ONE;
    assign size_ok   = (library_size != '0) && (library_size <= LIB_MAX);
    // The first result must seed both trackers even when it equals their init values.
    assign first_res = (count == '0);

    // Control FSM with all outputs registered; start has priority over a coincident result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            size_q        <= '0;
            count         <= '0;
            min_mse_value <= '1;
            min_mse_ref   <= '0;
            max_mse_value <= '0;
            max_mse_ref   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_RUN: begin
                    if (start) begin
                        if (size_ok) begin
                            // New pixel (or abort of the current one): reinitialise everything.
                            size_q        <= library_size;
                            count         <= '0;
                            min_mse_value <= '1;
                            min_mse_ref   <= '0;
                            max_mse_value <= '0;
                            max_mse_ref   <= '0;
                            busy          <= 1'b1;
                            state         <= S_RUN;
                            // A result in the same cycle is dropped and reported.
                            error         <= mse_valid;
                        end else begin
                            error <= 1'b1;
                        end
                    end else if (mse_valid) begin
                        if (state == S_RUN) begin
                            count <= count_nxt;
                            // Strict compares: ties keep the earlier result.
                            if (first_res || (mse_value < min_mse_value)) begin
                                min_mse_value <= mse_value;
                                min_mse_ref   <= mse_ref;
                            end
                            if (first_res || (mse_value > max_mse_value)) begin
                                max_mse_value <= mse_value;
                                max_mse_ref   <= mse_ref;
                            end
                            if (count_nxt == size_q) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // start is ignored here; it is taken only if held into IDLE.
                    state <= S_IDLE;
                    if (mse_valid) begin
                        error <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
